// File: rtl/meteor_sprite_renderer.sv
// rtl/meteor_sprite_renderer.sv - regenerates position from raw syncs and draws one falling meteor sprite
// Optional starfield background is compiled in with STARFIELD_EN.
module meteor_sprite_renderer #(
  parameter int VIDEO_WIDTH     = 3,
  parameter int TOTAL_COLS      = 800,
  parameter int TOTAL_ROWS      = 525,
  parameter int ACTIVE_COLS     = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int SPRITE_SIZE     = 16,
  parameter int STEP_PIX        = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic                   i_Spawn,
  input  logic [9:0]             i_Spawn_Col,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Meteor_Active,
  output logic                   o_Meteor_Landed
);
  typedef enum logic [1:0] {IDLE = 2'd0, FALLING = 2'd1, LANDED = 2'd2} state_t;

  localparam logic [9:0]  COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]  ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0]  ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0]  X_MAX    = 10'(ACTIVE_COLS - SPRITE_SIZE);
  localparam logic [9:0]  Y_REST   = 10'(ACTIVE_ROWS - SPRITE_SIZE);
  localparam logic [10:0] Y_LAND   = 11'(ACTIVE_ROWS - SPRITE_SIZE);
  localparam logic [10:0] STEP     = 11'(STEP_PIX);
  localparam logic [10:0] SIZE     = 11'(SPRITE_SIZE);
  localparam logic [3:0]  DIV_LAST = 4'(FRAMES_PER_STEP - 1);
  localparam logic [VIDEO_WIDTH-1:0] ONES = '1;

  logic       hs1_q, vs1_q, hs2_q, vs2_q;
  logic [9:0] col_q, col_d, row_q, row_d;
  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] div_q, div_d;
  logic       landed_q, landed_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic       update_pt, hit, in_active;
  logic [9:0] spawn_x;
  logic [10:0] y_step;

  // Stage 1: position counters, realigned on every VSync rising edge
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
    end
    if (i_VSync && !vs1_q) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      hs1_q <= i_HSync;
      vs1_q <= i_VSync;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign update_pt = (row_q == ACT_ROWS) && (col_q == 10'd0);
  assign spawn_x   = (i_Spawn_Col > X_MAX) ? X_MAX : i_Spawn_Col;
  assign y_step    = {1'b0, y_q} + STEP;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      div_q    <= '0;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      div_q    <= div_d;
      landed_q <= landed_d;
    end
  end

  // Movement is confined to the update point so a frame never shows two positions
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    div_d    = div_q;
    landed_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Spawn) begin
          x_d     = spawn_x;
          y_d     = '0;
          div_d   = '0;
          state_d = FALLING;
        end
      end
      FALLING: begin
        if (update_pt) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (y_step >= Y_LAND) begin
              y_d      = Y_REST;
              state_d  = LANDED;
              landed_d = 1'b1;
            end else begin
              y_d = y_step[9:0];
            end
          end else begin
            div_d = div_q + 4'd1;
          end
        end
      end
      LANDED: begin
        if (update_pt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_Meteor_Active = (state_q == FALLING) || (state_q == LANDED);
    in_active = (col_q < ACT_COLS) && (row_q < ACT_ROWS);
    hit = (state_q != IDLE) &&
          (col_q >= x_q) && ({1'b0, col_q} < {1'b0, x_q} + SIZE) &&
          (row_q >= y_q) && ({1'b0, row_q} < {1'b0, y_q} + SIZE);
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (in_active) begin
      if (hit && state_q == FALLING) begin
        red_d = ONES;
        grn_d = ONES >> 1;
      end else if (hit) begin
        red_d = ONES;
      end
`ifdef STARFIELD_EN
      else if (col_q[3:0] == 4'd0 && row_q[3:0] == col_q[7:4]) begin
        red_d = ONES;
        grn_d = ONES;
        blu_d = ONES;
      end
`endif
    end
  end

  // Stage 2: colour and twice-delayed syncs leave together
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign o_HSync         = hs2_q;
  assign o_VSync         = vs2_q;
  assign o_Red_Video     = red_q;
  assign o_Grn_Video     = grn_q;
  assign o_Blu_Video     = blu_q;
  assign o_Meteor_Landed = landed_q;
endmodule

// File: tb/tb_meteor_sprite_renderer.sv
// tb/tb_meteor_sprite_renderer.sv - scoreboard bench for meteor_sprite_renderer (honours STARFIELD_EN)
module tb_meteor_sprite_renderer;
  localparam int VW = 3, TC = 56, TR = 36, AC = 48, AR = 32, SS = 4, SP = 4, FPS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hsync_in = 1'b0, vsync_in = 1'b0, spawn = 1'b0;
  logic [9:0] spawn_col = '0;
  logic hsync_o, vsync_o, active_o, landed_o;
  logic [VW-1:0] red_o, grn_o, blu_o;

  meteor_sprite_renderer #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR), .SPRITE_SIZE(SS), .STEP_PIX(SP), .FRAMES_PER_STEP(FPS)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_HSync(hsync_in), .i_VSync(vsync_in),
    .i_Spawn(spawn), .i_Spawn_Col(spawn_col),
    .o_HSync(hsync_o), .o_VSync(vsync_o),
    .o_Red_Video(red_o), .o_Grn_Video(grn_o), .o_Blu_Video(blu_o),
    .o_Meteor_Active(active_o), .o_Meteor_Landed(landed_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hs;
    logic vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic chk_rgb;
    int row;
    int col;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int gen_row = 3, gen_col = 17;
  bit aligned = 1'b0;
  int exp_mode = 0, exp_x = 0, exp_y = 0;
  int landed_count = 0;

  // Per-frame meteor position after a spawn in blanking, two frames per 4-row step
  int y_tab[16] = '{0, 0, 4, 4, 8, 8, 12, 12, 16, 16, 20, 20, 24, 24, 28, 0};
  int m_tab[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 0};

  always @(negedge clk) if (landed_o === 1'b1) landed_count <= landed_count + 1;

  task automatic check(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
`ifdef STARFIELD_EN
    logic [9:0] cv, rv;
    cv = 10'(gen_col);
    rv = 10'(gen_row);
`endif
    hsync_in = (gen_col < AC);
    vsync_in = (gen_row < AR);
    if (gen_row == 0 && gen_col == 0 && !rst) aligned = 1'b1;
    e.hs = hsync_in;
    e.vs = vsync_in;
    e.row = gen_row;
    e.col = gen_col;
    e.r = '0;
    e.g = '0;
    e.b = '0;
    if (hsync_in && vsync_in) begin
      if (exp_mode != 0 && gen_col >= exp_x && gen_col < exp_x + SS &&
          gen_row >= exp_y && gen_row < exp_y + SS) begin
        e.r = 3'd7;
        e.g = (exp_mode == 1) ? 3'd3 : 3'd0;
      end
`ifdef STARFIELD_EN
      else if (cv[3:0] == 4'd0 && rv[3:0] == cv[7:4]) begin
        e.r = 3'd7;
        e.g = 3'd7;
        e.b = 3'd7;
      end
`endif
    end
`ifdef STARFIELD_EN
    e.chk_rgb = aligned;
`else
    e.chk_rgb = 1'b1;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (gen_col == TC - 1) begin
      gen_col = 0;
      gen_row = (gen_row == TR - 1) ? 0 : gen_row + 1;
    end else begin
      gen_col++;
    end
  endtask

  task automatic run_to(int r, int c);
    while (!(gen_row == r && gen_col == c)) step();
  endtask

  task automatic do_spawn(int c);
    spawn = 1'b1;
    spawn_col = 10'(c);
    step();
    spawn = 1'b0;
  endtask

  // Monitor: compares every output cycle against the queued expectation two cycles back
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_checks++;
        if ({hsync_o, vsync_o, red_o, grn_o, blu_o, active_o, landed_o} != '0) begin
          n_fail++;
          $display("FAIL reset_outputs: got hs=%b vs=%b rgb=%0d/%0d/%0d act=%b land=%b expected all 0",
                   hsync_o, vsync_o, red_o, grn_o, blu_o, active_o, landed_o);
        end
        sb.delete();
      end else if (sb.size() > 2) begin
        e = sb.pop_front();
        n_checks++;
        if (hsync_o !== e.hs || vsync_o !== e.vs) begin
          n_fail++;
          $display("FAIL sync r=%0d c=%0d: got hs=%b vs=%b expected hs=%b vs=%b",
                   e.row, e.col, hsync_o, vsync_o, e.hs, e.vs);
        end
        if (e.chk_rgb) begin
          n_checks++;
          if (red_o !== e.r || grn_o !== e.g || blu_o !== e.b) begin
            n_fail++;
            $display("FAIL rgb r=%0d c=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     e.row, e.col, red_o, grn_o, blu_o, e.r, e.g, e.b);
          end
        end
      end
    end
  end

  initial begin
    // Reset held from mid-line, then two idle frames
    repeat (4) step();
    rst = 1'b0;
    step();
    check("idle_active", int'(active_o), 0);
    run_to(0, 0);
    repeat (2) begin
      step();
      run_to(0, 0);
    end
    check("idle_active_after_frames", int'(active_o), 0);
    check("idle_landed_count", landed_count, 0);

    // Spawn at col 10 in blanking, follow the full fall and landing
    run_to(AR + 2, 0);
    do_spawn(10);
    exp_mode = 1;
    exp_x = 10;
    exp_y = 0;
    check("spawn_active", int'(active_o), 1);
    for (int f = 0; f < 16; f++) begin
      run_to(0, 0);
      exp_mode = m_tab[f];
      exp_y = y_tab[f];
      if (f == 13) check("landed_before_last_step", landed_count, 0);
      if (f == 14) begin
        check("landed_pulse_once", landed_count, 1);
        check("landed_active", int'(active_o), 1);
      end
      if (f == 15) check("idle_after_landed", int'(active_o), 0);
      step();
      if (f == 3) begin
        run_to(AR + 2, 0);
        do_spawn(5);
      end
    end
    run_to(0, 0);
    check("landed_total", landed_count, 1);

    // Spawn past the right edge clamps X to AC-SS, then reset mid-frame
    run_to(AR + 2, 0);
    do_spawn(60);
    exp_mode = 1;
    exp_x = AC - SS;
    exp_y = 0;
    for (int f = 0; f < 3; f++) begin
      run_to(0, 0);
      exp_y = (f == 2) ? 4 : 0;
      step();
    end
    run_to(5, 10);
    rst = 1'b1;
    exp_mode = 0;
    aligned = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_mid_frame_idle", int'(active_o), 0);

    // Spawn coincident with the update point: no move in the following frame
    run_to(0, 0);
    run_to(AR, 1);
    do_spawn(31);
    exp_mode = 1;
    exp_x = 31;
    exp_y = 0;
    for (int f = 0; f < 3; f++) begin
      run_to(0, 0);
      exp_y = (f == 2) ? 4 : 0;
      step();
    end
    run_to(0, 0);
    repeat (3) step();
    check("update_spawn_active", int'(active_o), 1);
    check("update_spawn_no_land", landed_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
